// File: rtl/branch_redirect_ctrl.sv
// Pipeline redirect controller: turns execute/writeback PC redirects and load-use
// hazards into PC control signals, and tracks PC-writing loads until writeback.
package branch_redirect_pkg;
  localparam int unsigned WORD = 32;

  typedef enum logic {
    NO_BRANCH   = 1'b0,
    TAKE_BRANCH = 1'b1
  } take_branch_ctrl_sig;

  typedef enum logic {
    NO_BRANCH_FROM_WB = 1'b0,
    BRANCH_FROM_WB    = 1'b1
  } branch_from_wb;

  typedef enum logic {
    NO_STALL       = 1'b0,
    STALL_PIPELINE = 1'b1
  } stall_pipeline_sig;
endpackage

module branch_redirect_ctrl
  import branch_redirect_pkg::*;
#(
  parameter int unsigned WB_TIMEOUT = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                decode_valid_i,
  input  logic                pc_write_in_decode_i,
  input  logic                load_use_hazard_i,
  input  logic                ex_branch_taken_i,
  input  logic [WORD-1:0]     ex_branch_target_i,
  input  logic                wb_pc_write_i,
  input  logic [WORD-1:0]     wb_pc_value_i,
  output take_branch_ctrl_sig take_branch_o,
  output logic [WORD-1:0]     branch_pc_value_o,
  output branch_from_wb       branch_from_wb_o,
  output logic [WORD-1:0]     pop_pc_value_o,
  output stall_pipeline_sig   stall_pipeline_o,
  output logic                flush_fetch_decode_o,
  output logic                flush_decode_execute_o,
  output logic                bubble_decode_o,
  output logic                busy_o,
  output logic                error_o,
  output logic [15:0]         redirect_count_o
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned RC_W  = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_WB = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_set;
  logic             redirect;

  assign branch_pc_value_o = ex_branch_target_i;
  assign pop_pc_value_o    = wb_pc_value_i;

  // Next state and control outputs; redirect priority: execute, WB, wait stall, load-use.
  always_comb begin
    state_d                = state_q;
    wait_cnt_d             = wait_cnt_q;
    err_set                = 1'b0;
    take_branch_o          = NO_BRANCH;
    branch_from_wb_o       = NO_BRANCH_FROM_WB;
    stall_pipeline_o       = NO_STALL;
    flush_fetch_decode_o   = 1'b0;
    flush_decode_execute_o = 1'b0;
    bubble_decode_o        = 1'b0;
    busy_o                 = 1'b0;

    if (reset_i) begin
      state_d    = IDLE;
      wait_cnt_d = '0;
    end else begin
      busy_o = (state_q == WAIT_WB);
      if (ex_branch_taken_i) begin
        take_branch_o          = TAKE_BRANCH;
        flush_fetch_decode_o   = 1'b1;
        flush_decode_execute_o = 1'b1;
        state_d                = IDLE;
      end else if (wb_pc_write_i) begin
        branch_from_wb_o     = BRANCH_FROM_WB;
        flush_fetch_decode_o = 1'b1;
        state_d              = IDLE;
      end else if (state_q == WAIT_WB) begin
        if (wait_cnt_q == '0) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          stall_pipeline_o = STALL_PIPELINE;
          bubble_decode_o  = 1'b1;
          wait_cnt_d       = wait_cnt_q - CNT_W'(1);
        end
      end else if (decode_valid_i && pc_write_in_decode_i) begin
        // PC-writing load proceeds to execute; fetch holds until its WB write.
        stall_pipeline_o = STALL_PIPELINE;
        state_d          = WAIT_WB;
        wait_cnt_d       = CNT_W'(WB_TIMEOUT - 1);
      end else if (load_use_hazard_i) begin
        stall_pipeline_o = STALL_PIPELINE;
        bubble_decode_o  = 1'b1;
      end
    end
  end

  assign redirect = (take_branch_o == TAKE_BRANCH) || (branch_from_wb_o == BRANCH_FROM_WB);

  // State, wait counter, sticky error and saturating redirect counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= IDLE;
      wait_cnt_q       <= '0;
      error_o          <= 1'b0;
      redirect_count_o <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (err_set) begin
        error_o <= 1'b1;
      end
      if (redirect && (redirect_count_o != {RC_W{1'b1}})) begin
        redirect_count_o <= redirect_count_o + RC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: single-cycle vector table in IDLE plus
// hand-written sequences for POP {PC}, simultaneous events, timeout and saturation.
module tb_branch_redirect_ctrl;
  import branch_redirect_pkg::*;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic                decode_valid_i;
  logic                pc_write_in_decode_i;
  logic                load_use_hazard_i;
  logic                ex_branch_taken_i;
  logic [WORD-1:0]     ex_branch_target_i;
  logic                wb_pc_write_i;
  logic [WORD-1:0]     wb_pc_value_i;
  take_branch_ctrl_sig take_branch_o;
  logic [WORD-1:0]     branch_pc_value_o;
  branch_from_wb       branch_from_wb_o;
  logic [WORD-1:0]     pop_pc_value_o;
  stall_pipeline_sig   stall_pipeline_o;
  logic                flush_fetch_decode_o;
  logic                flush_decode_execute_o;
  logic                bubble_decode_o;
  logic                busy_o;
  logic                error_o;
  logic [15:0]         redirect_count_o;

  branch_redirect_ctrl #(.WB_TIMEOUT(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .decode_valid_i(decode_valid_i), .pc_write_in_decode_i(pc_write_in_decode_i),
    .load_use_hazard_i(load_use_hazard_i), .ex_branch_taken_i(ex_branch_taken_i),
    .ex_branch_target_i(ex_branch_target_i), .wb_pc_write_i(wb_pc_write_i),
    .wb_pc_value_i(wb_pc_value_i), .take_branch_o(take_branch_o),
    .branch_pc_value_o(branch_pc_value_o), .branch_from_wb_o(branch_from_wb_o),
    .pop_pc_value_o(pop_pc_value_o), .stall_pipeline_o(stall_pipeline_o),
    .flush_fetch_decode_o(flush_fetch_decode_o),
    .flush_decode_execute_o(flush_decode_execute_o),
    .bubble_decode_o(bubble_decode_o), .busy_o(busy_o), .error_o(error_o),
    .redirect_count_o(redirect_count_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int exp_rc = 0;

  typedef struct {
    logic        dv, pcw, lu, ex;
    logic [31:0] tgt;
    logic        take, stall, ffd, fde, bub;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and apply inputs; outputs settle 1 time unit later.
  task automatic drive(input logic rst, input logic dv, input logic pcw, input logic lu,
                       input logic ex, input logic [31:0] tgt, input logic wb,
                       input logic [31:0] wbv);
    @(negedge clk_i);
    reset_i = rst; decode_valid_i = dv; pc_write_in_decode_i = pcw;
    load_use_hazard_i = lu; ex_branch_taken_i = ex; ex_branch_target_i = tgt;
    wb_pc_write_i = wb; wb_pc_value_i = wbv;
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic enter_wait();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset with redirect inputs active: every control output deasserted.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h40);
      chk("rst_take", 32'(take_branch_o), 32'(NO_BRANCH));
      chk("rst_bfw", 32'(branch_from_wb_o), 32'(NO_BRANCH_FROM_WB));
      chk("rst_stall", 32'(stall_pipeline_o), 32'(NO_STALL));
      chk("rst_flush", {30'h0, flush_fetch_decode_o, flush_decode_execute_o}, 32'h0);
      chk("rst_bubble", 32'(bubble_decode_o), 32'h0);
    end
    idle_cycle();
    chk("post_rst_err", 32'(error_o), 32'h0);
    chk("post_rst_rc", 32'(redirect_count_o), 32'h0);
    chk("post_rst_busy", 32'(busy_o), 32'h0);

    // Single-cycle IDLE vectors; none of them leave IDLE.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, vecs[i].dv, vecs[i].pcw, vecs[i].lu, vecs[i].ex, vecs[i].tgt, 1'b0, 32'h0);
      chk($sformatf("v%0d_take", i), 32'(take_branch_o), 32'(vecs[i].take));
      chk($sformatf("v%0d_stall", i), 32'(stall_pipeline_o), 32'(vecs[i].stall));
      chk($sformatf("v%0d_ffd", i), 32'(flush_fetch_decode_o), 32'(vecs[i].ffd));
      chk($sformatf("v%0d_fde", i), 32'(flush_decode_execute_o), 32'(vecs[i].fde));
      chk($sformatf("v%0d_bub", i), 32'(bubble_decode_o), 32'(vecs[i].bub));
      chk($sformatf("v%0d_bpc", i), branch_pc_value_o, vecs[i].tgt);
      chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'h0);
      chk($sformatf("v%0d_rc", i), 32'(redirect_count_o), 32'(exp_rc));
      if (vecs[i].take) exp_rc++;
    end

    // POP {PC} nominal: entry at T, WB write at T+3; decode noise ignored while waiting.
    enter_wait();
    chk("pop_T_stall", 32'(stall_pipeline_o), 32'(STALL_PIPELINE));
    chk("pop_T_bub", 32'(bubble_decode_o), 32'h0);
    chk("pop_T_flush", {30'h0, flush_fetch_decode_o, flush_decode_execute_o}, 32'h0);
    chk("pop_T_busy", 32'(busy_o), 32'h0);
    for (int i = 1; i <= 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk($sformatf("pop_T%0d_stall", i), 32'(stall_pipeline_o), 32'(STALL_PIPELINE));
      chk($sformatf("pop_T%0d_bub", i), 32'(bubble_decode_o), 32'h1);
      chk($sformatf("pop_T%0d_busy", i), 32'(busy_o), 32'h1);
      chk($sformatf("pop_T%0d_bfw", i), 32'(branch_from_wb_o), 32'(NO_BRANCH_FROM_WB));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0040);
    chk("pop_T3_bfw", 32'(branch_from_wb_o), 32'(BRANCH_FROM_WB));
    chk("pop_T3_ffd", 32'(flush_fetch_decode_o), 32'h1);
    chk("pop_T3_fde", 32'(flush_decode_execute_o), 32'h0);
    chk("pop_T3_stall", 32'(stall_pipeline_o), 32'(NO_STALL));
    chk("pop_T3_busy", 32'(busy_o), 32'h1);
    chk("pop_T3_val", pop_pc_value_o, 32'h0000_0040);
    exp_rc++;
    idle_cycle();
    chk("pop_T4_busy", 32'(busy_o), 32'h0);
    chk("pop_T4_stall", 32'(stall_pipeline_o), 32'(NO_STALL));
    chk("pop_T4_rc", 32'(redirect_count_o), 32'(exp_rc));

    // Execute and WB redirect together while waiting: execute wins, counted once.
    enter_wait();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0044);
    chk("both_take", 32'(take_branch_o), 32'(TAKE_BRANCH));
    chk("both_bfw", 32'(branch_from_wb_o), 32'(NO_BRANCH_FROM_WB));
    chk("both_fde", 32'(flush_decode_execute_o), 32'h1);
    exp_rc++;
    idle_cycle();
    chk("both_busy", 32'(busy_o), 32'h0);
    chk("both_rc", 32'(redirect_count_o), 32'(exp_rc));

    // Reset during WAIT_WB abandons the wait without an error.
    enter_wait();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    exp_rc = 0;
    for (int i = 0; i < 10; i++) idle_cycle();
    chk("rstwait_busy", 32'(busy_o), 32'h0);
    chk("rstwait_err", 32'(error_o), 32'h0);
    chk("rstwait_rc", 32'(redirect_count_o), 32'h0);

    // Timeout: WAIT_WB spans T+1..T+8, error visible from T+9.
    enter_wait();
    chk("to_T_stall", 32'(stall_pipeline_o), 32'(STALL_PIPELINE));
    for (int i = 1; i <= 7; i++) begin
      idle_cycle();
      chk($sformatf("to_T%0d_stall", i), 32'(stall_pipeline_o), 32'(STALL_PIPELINE));
      chk($sformatf("to_T%0d_busy", i), 32'(busy_o), 32'h1);
    end
    idle_cycle();
    chk("to_T8_busy", 32'(busy_o), 32'h1);
    chk("to_T8_err", 32'(error_o), 32'h0);
    idle_cycle();
    chk("to_T9_err", 32'(error_o), 32'h1);
    chk("to_T9_busy", 32'(busy_o), 32'h0);
    chk("to_T9_stall", 32'(stall_pipeline_o), 32'(NO_STALL));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0600, 1'b0, 32'h0);
    exp_rc++;
    enter_wait();
    idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0080);
    exp_rc++;
    idle_cycle();
    chk("to_sticky_err", 32'(error_o), 32'h1);
    chk("to_rc", 32'(redirect_count_o), 32'(exp_rc));

    // Saturation: 65540 back-to-back execute redirects.
    for (int i = 0; i < 65540; i++)
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    idle_cycle();
    chk("sat_rc", 32'(redirect_count_o), 32'h0000_FFFF);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    idle_cycle();
    chk("sat_hold", 32'(redirect_count_o), 32'h0000_FFFF);
    chk("sat_err", 32'(error_o), 32'h1);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle_cycle();
    chk("final_err", 32'(error_o), 32'h0);
    chk("final_rc", 32'(redirect_count_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
